// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the busy-counter width.
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: operands, op and current HI/LO in,
// 64-bit {HI,LO} result out. Accumulate ops exist only with MDU_MADD_EN.
import mdu_pkg::*;

module mdu_arith (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_old,
    input  logic [31:0] lo_old,
    output logic [63:0] result
);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        q_s, r_s, q_u, r_u;

    assign sa     = {{32{a[31]}}, a};
    assign sb     = {{32{b[31]}}, b};
    assign ua     = {32'd0, a};
    assign ub     = {32'd0, b};
    assign prod_s = sa * sb;
    assign prod_u = ua * ub;

    // Signed divide: zero divisor and the single overflow case are fixed up explicitly
    always_comb begin
        q_s = 32'd0;
        r_s = 32'd0;
        if (b == 32'd0) begin
            q_s = 32'hFFFF_FFFF;
            r_s = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(a) / $signed(b);
            r_s = $signed(a) % $signed(b);
        end
    end

    // Unsigned divide with the same divide-by-zero convention
    always_comb begin
        q_u = 32'd0;
        r_u = 32'd0;
        if (b == 32'd0) begin
            q_u = 32'hFFFF_FFFF;
            r_u = a;
        end else begin
            q_u = a / b;
            r_u = a % b;
        end
    end

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_old, lo_old};
`else
    // HI/LO only feed the accumulate path, which is absent in this build
    logic unused_acc;
    assign unused_acc = ^{hi_old, lo_old};
`endif

    // Result select by op
    always_comb begin
        result = 64'd0;
        case (op_t'(op))
            MULT:  result = prod_s;
            MULTU: result = prod_u;
            DIV:   result = {r_s, q_s};
            DIVU:  result = {r_u, q_u};
`ifdef MDU_MADD_EN
            MADD:  result = acc + prod_s;
            MADDU: result = acc + prod_u;
            MSUB:  result = acc - prod_s;
            MSUBU: result = acc - prod_u;
`endif
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at the start edge, held in a pending register and committed when
// the busy counter expires. Optional MADD/MSUB ops: define MDU_MADD_EN.
import mdu_pkg::*;

module mult_div_unit #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [63:0]        pend;
    logic [63:0]        result;
    logic               is_mul, is_div;

    mdu_arith u_arith (
        .op     (op),
        .a      (rs_data),
        .b      (rt_data),
        .hi_old (hi),
        .lo_old (lo),
        .result (result)
    );

    // Classify the op into its latency class
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op_t'(op))
            MULT, MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: is_mul = 1'b1;
`endif
            DIV, DIVU:   is_div = 1'b1;
            default: ;
        endcase
    end

    // IDLE/RUN control, busy counter, pending result and HI/LO commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            pend  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            pend  <= result;
                            count <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (op_t'(op) == MTHI) begin
                            hi <= rs_data;
                        end else if (op_t'(op) == MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                RUN: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        hi    <= pend[63:32];
                        lo    <= pend[31:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed ops with a scoreboard of
// expected {HI,LO} results, latency counting, hold, ignore and reset-abort cases.
import mdu_pkg::*;

module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy;
    logic [31:0] hi, lo;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    logic [63:0] sb_q[$];

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multi-cycle op, count busy cycles, then compare against the scoreboard.
    task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int n, input bit retrig, input string tag);
        int cyc;
        logic [63:0] want;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = NOP; rs_data = $urandom; rt_data = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (cyc == 1) check({tag, "_hold"}, {hi, lo}, {mhi, mlo});
            if (retrig && cyc == 2) begin
                start = 1'b1; op = MULT; rs_data = 32'd5; rt_data = 32'd5;
            end
            if (retrig && cyc == 3) begin
                start = 1'b0; op = NOP;
            end
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(cyc), 64'(n));
        want = sb_q.pop_front();
        check(tag, {hi, lo}, want);
        {mhi, mlo} = want;
    endtask

    // Single-edge op (MTHI/MTLO/NOP/undefined): expect no busy and the given HI/LO.
    task automatic run_one(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = 32'h5a5a_5a5a;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check(tag, {hi, lo}, {ehi, elo});
        mhi = ehi; mlo = elo;
    endtask

    initial begin
        bit seen_bad;
        reset = 1'b1; start = 1'b0; op = NOP; rs_data = 32'd0; rt_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk) reset = 1'b0;

        run_md(MULT,  32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b0, "mult");
        run_md(MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 1'b0, "multu");
        run_md(DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0, "div_neg");
        run_md(DIVU,  32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 10, 1'b0, "divu_by0");
        run_md(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0, "div_ovf");
        run_md(DIV,   32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, 1'b0, "div_negdiv");
        run_md(DIV,   32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 10, 1'b0, "div_by0");
        run_md(DIVU,  32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, 1'b0, "divu");

        run_one(MTLO, 32'h0000_1234, mhi, 32'h0000_1234, "mtlo");
        run_one(MTHI, 32'hCAFE_0001, 32'hCAFE_0001, mlo, "mthi");
        run_one(NOP,  32'hDEAD_BEEF, mhi, mlo, "nop");
        run_one(4'd15, 32'hDEAD_BEEF, mhi, mlo, "undef");
`ifndef MDU_MADD_EN
        run_one(MADDU, 32'd1, mhi, mlo, "madd_off");
`endif

        // Start while RUN is ignored: latency and result stay those of 3*4
        run_md(MULT, 32'd3, 32'd4, 64'd12, 5, 1'b1, "retrig");
        @(posedge clk); #1;
        check("retrig_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a run discards the pending product
        run_one(MTLO, 32'd0, mhi, 32'd0, "pre_lo");
        run_one(MTHI, 32'd0, 32'd0, 32'd0, "pre_hi");
        @(negedge clk);
        start = 1'b1; op = MULT; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = MULT; rs_data = 32'd5; rt_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        check("abort_still_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_rst", {31'd0, busy, hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;
        seen_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || lo !== 32'd0 || hi !== 32'd0) seen_bad = 1'b1;
        end
        check("abort_no_result", {63'd0, seen_bad}, 64'd0);
        mhi = 32'd0; mlo = 32'd0;

`ifdef MDU_MADD_EN
        run_one(MTHI, 32'd0, 32'd0, mlo, "madd_hi");
        run_one(MTLO, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, "madd_lo");
        run_md(MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 1'b0, "maddu");
        run_md(MSUB,  32'hFFFF_FFFF, 32'd1, 64'h0000_0001_0000_0001, 5, 1'b0, "msub");
        run_md(MADD,  32'hFFFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFF, 5, 1'b0, "madd");
        run_md(MSUBU, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_0000_0000, 5, 1'b0, "msubu");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
